accelerator_instruction_issuer: RTL

Host-side sequencer that drives the accelerator's `instruction` port and collects its `dataOut` word. A host pushes program entries into a local program FIFO. Each entry holds an instruction word, a hold count and a capture flag. After `start`, the block issues the entries cycle-accurately to the accelerator. It samples `dataOut` a fixed number of cycles after each capture-flagged instruction and returns the samples through a valid/ready result FIFO.

---
 rtl/accel_pkg.sv | 62 ++++++
 rtl/sync_fifo.sv | 59 +++++
 rtl/accelerator_instruction_issuer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : accel_pkg                                                  |
// | Purpose  : Shared accelerator instruction geometry, NOP word and the  |
// |            issuer state encoding.                                     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int c_OPCODE_W = 4;
  localparam int c_MODE_W   = 2;

  // NOP is the all-zero word; slice the low bits for any instruction width.
  localparam int              c_NOP_MAX_W = 256;
  localparam logic [c_NOP_MAX_W-1:0] c_NOP = '0;

  // Width of each argument field: enough to address a PE, at least 2 bits.
  function automatic int insW(input int depth);
    return (depth > 2) ? depth : 2;
  endfunction

  // Width of the data field: the wider of the PE row and the datapath word.
  function automatic int insD(input int depth, input int w);
    int d;
    d = 1 << depth;
    return (d > w) ? d : w;
  endfunction

  function automatic int insWidthOf(input int depth, input int w);
    return c_OPCODE_W + c_MODE_W + 2 * insW(depth) + insD(depth, w);
  endfunction

  // Field LSB offsets, msb->lsb order: opcode, mode, argA, argB, data.
  function automatic int dataLsb();
    return 0;
  endfunction

  function automatic int argBLsb(input int depth, input int w);
    return insD(depth, w);
  endfunction

  function automatic int argALsb(input int depth, input int w);
    return insD(depth, w) + insW(depth);
  endfunction

  function automatic int modeLsb(input int depth, input int w);
    return insD(depth, w) + 2 * insW(depth);
  endfunction

  function automatic int opcodeLsb(input int depth, input int w);
    return modeLsb(depth, w) + c_MODE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sync_fifo                                                  |
// | Purpose  : Single-clock first-word-fall-through FIFO with occupancy   |
// |            count. DEPTH must be a power of two, at least 2.           |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       clr,
  input  logic                       wrEn,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       rdEn,
  output logic [WIDTH-1:0]           rdData,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wrPtr;
  logic [c_AW:0]    r_rdPtr;
  logic             w_wr;
  logic             w_rd;

  // Pointers carry a wrap bit, so the difference is the occupancy and its
  // MSB alone flags a full FIFO.
  assign count  = r_wrPtr - r_rdPtr;
  assign w_wr   = wrEn && !count[c_AW];
  assign w_rd   = rdEn && (count != '0);
  assign rdData = r_mem[r_rdPtr[c_AW-1:0]];

  // Storage array: written on accepted pushes only.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wrPtr[c_AW-1:0]] <= wrData;
    end
  end

  // Read/write pointers; clear empties the FIFO and wins over traffic.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wr) r_wrPtr <= r_wrPtr + (c_AW+1)'(1);
      if (w_rd) r_rdPtr <= r_rdPtr + (c_AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/accelerator_instruction_issuer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : accelerator_instruction_issuer                             |
// | Purpose  : Replays a host-loaded program onto the accelerator         |
// |            instruction port cycle-accurately and returns dataOut      |
// |            samples taken READ_LAT cycles after capture entries.       |
// | Options  : ISSUER_PERF_EN - implements issueCount/stallCount,         |
// |            otherwise both ports read as zero.                         |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module accelerator_instruction_issuer
  import accel_pkg::*;
#(
  parameter int depth    = 3,
  parameter int W        = 16,
  parameter int insWidth = insWidthOf(depth, W),
  parameter int PD       = 16,
  parameter int RD       = 4,
  parameter int HW       = 8,
  parameter int READ_LAT = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                progValid,
  output logic                progReady,
  input  logic [insWidth-1:0] progIns,
  input  logic [HW-1:0]       progHold,
  input  logic                progCapture,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [insWidth-1:0] instruction,
  input  logic [W-1:0]        dataOut,
  output logic                resValid,
  input  logic                resReady,
  output logic [W-1:0]        resData,
  output logic [31:0]         issueCount,
  output logic [31:0]         stallCount
);

  localparam int c_PAW = $clog2(PD);
  localparam int c_RAW = $clog2(RD);
  localparam int c_PW  = insWidth + HW + 1;
  localparam logic [insWidth-1:0] c_NOP_WORD = c_NOP[insWidth-1:0];

  state_t              r_state;
  state_t              w_nextState;
  logic [HW-1:0]       r_holdCnt;
  logic [insWidth-1:0] r_instruction;
  logic [READ_LAT-1:0] r_capPipe;
  logic                r_done;

  logic [c_PAW:0]      w_progCount;
  logic [c_PW-1:0]     w_progHead;
  logic [insWidth-1:0] w_headIns;
  logic [HW-1:0]       w_headHold;
  logic                w_headCap;
  logic                w_progEmpty;
  logic [c_RAW:0]      w_resCount;
  logic [31:0]         w_inflight;
  logic                w_creditOk;
  logic                w_capOut;
  logic                w_pop;
  logic                w_doneNext;

  sync_fifo #(.WIDTH(c_PW), .DEPTH(PD)) u_progFifo (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (abort),
    .wrEn   (progValid && progReady),
    .wrData ({progIns, progHold, progCapture}),
    .rdEn   (w_pop),
    .rdData (w_progHead),
    .count  (w_progCount)
  );

  sync_fifo #(.WIDTH(W), .DEPTH(RD)) u_resFifo (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (1'b0),
    .wrEn   (w_capOut),
    .wrData (dataOut),
    .rdEn   (resReady),
    .rdData (resData),
    .count  (w_resCount)
  );

  assign {w_headIns, w_headHold, w_headCap} = w_progHead;
  assign w_progEmpty = (w_progCount == '0);
  assign progReady   = !w_progCount[c_PAW];
  assign resValid    = (w_resCount != '0);

  // A capture may only issue when every in-flight and stored result still
  // fits in the result FIFO, so it can never overflow.
  assign w_inflight  = 32'($countones(r_capPipe));
  assign w_creditOk  = (w_inflight + 32'(w_resCount)) < 32'(RD);
  assign w_capOut    = r_capPipe[READ_LAT-1] && !abort;

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign instruction = r_instruction;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state, pop and done decode; abort overrides everything.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_doneNext  = 1'b0;
    if (abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_progEmpty) w_doneNext  = 1'b1;
            else             w_nextState = RUN;
          end
        end
        RUN: begin
          if (w_progEmpty) begin
            w_nextState = DRAIN;
          end else if (!(w_headCap && !w_creditOk)) begin
            w_pop = 1'b1;
            if (w_headHold != '0) w_nextState = HOLD;
          end
        end
        HOLD: begin
          if (r_holdCnt <= HW'(1)) w_nextState = RUN;
        end
        DRAIN: begin
          if (r_capPipe == '0) begin
            w_nextState = IDLE;
            w_doneNext  = 1'b1;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Instruction/hold registers: load on pop, freeze during HOLD, else NOP.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instruction <= '0;
      r_holdCnt     <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_doneNext;
      if (w_pop) begin
        r_instruction <= w_headIns;
        r_holdCnt     <= w_headHold;
      end else if (r_state == HOLD && !abort) begin
        r_holdCnt     <= r_holdCnt - HW'(1);
      end else begin
        r_instruction <= c_NOP_WORD;
      end
    end
  end

  generate
    if (READ_LAT == 1) begin : g_capLatOne
      // Single-stage capture pipeline.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)      r_capPipe <= '0;
        else if (abort) r_capPipe <= '0;
        else            r_capPipe <= w_pop && w_headCap;
      end
    end else begin : g_capLatMulti
      // Capture bits enter once per issued entry and shift toward the sample point.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)      r_capPipe <= '0;
        else if (abort) r_capPipe <= '0;
        else            r_capPipe <= {r_capPipe[READ_LAT-2:0], w_pop && w_headCap};
      end
    end
  endgenerate

`ifdef ISSUER_PERF_EN
  logic        w_stall;
  logic [31:0] r_issueCount;
  logic [31:0] r_stallCount;

  assign w_stall = (r_state == RUN) && !abort && !w_progEmpty && w_headCap && !w_creditOk;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_issueCount <= '0;
      r_stallCount <= '0;
    end else begin
      if (w_pop)   r_issueCount <= r_issueCount + 32'd1;
      if (w_stall) r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign issueCount = r_issueCount;
  assign stallCount = r_stallCount;
`else
  assign issueCount = '0;
  assign stallCount = '0;
`endif

endmodule
`default_nettype wire
